// File: rtl/stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stall-bus layout,
// enable/reset polarities and FSM state encodings.
package stall_ctrl_pkg;

  localparam int STALL_W = 6;
  localparam int CNT_W   = 6;

  localparam logic        STALL_ENABLE  = 1'b1;
  localparam logic        STALL_DISABLE = 1'b0;
  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

  // Stall-bus patterns: bit0 PC .. bit5 WB
  localparam logic [STALL_W-1:0] STALL_NONE = {STALL_W{STALL_DISABLE}};
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    IDLE   = 1'b0,
    MC_RUN = 1'b1
  } state_e;

  // A requested length of zero behaves as a single-cycle op.
  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
    return (len == '0) ? CNT_W'(1) : len;
  endfunction

endpackage

// File: rtl/stall_ctrl_mc_timer.sv
// Down-counter tracking the remaining EX-stall cycles of a multi-cycle op.
module mc_timer
  import stall_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             freeze_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (!freeze_i && dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: prioritises flush, MEM wait, EX multi-cycle
// ops and ID load-use hazards onto a six-bit stall bus.
module stall_ctrl
  import stall_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               stallreq_mem,
  input  logic               mc_start,
  input  logic [CNT_W-1:0]   mc_len,
  input  logic               flush_req,
  input  logic [31:0]        flush_pc,
  output logic [STALL_W-1:0] ctrl_stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               mc_done,
  output logic               busy,
  output logic [31:0]        stall_cycles
);

  state_e           state_q;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             active;
  logic             mc_fire;
  logic             ex_stall;
  logic [31:0]      stall_cycles_q, stall_cycles_d;

  assign active   = (rst != RST_ENABLE);
  assign len_eff  = eff_len(mc_len);
  // An op is only accepted when nothing of higher priority is holding EX.
  assign mc_fire  = active && (state_q == IDLE) && mc_start && !flush_req && !stallreq_mem;
  assign ex_stall = mc_fire || (active && (state_q == MC_RUN));

  mc_timer u_mc_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (flush_req),
    .load_i     (mc_fire && (len_eff > CNT_W'(1))),
    .load_val_i (len_eff - CNT_W'(2)),
    .freeze_i   (stallreq_mem),
    .dec_i      (state_q == MC_RUN),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= IDLE;
    end else if (flush_req) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (mc_fire && (len_eff > CNT_W'(1))) state_q <= MC_RUN;
        MC_RUN:  if (!stallreq_mem && cnt_zero)         state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_stall = STALL_NONE;
    flush      = 1'b0;
    new_pc     = ZERO_WORD;
    if (active) begin
      if (flush_req) begin
        flush  = 1'b1;
        new_pc = flush_pc;
      end else if (stallreq_mem) begin
        ctrl_stall = STALL_MEM;
      end else if (ex_stall) begin
        ctrl_stall = STALL_EX;
      end else if (stallreq_id) begin
        ctrl_stall = STALL_ID;
      end
    end
  end

  always_comb begin
    mc_done = 1'b0;
    if (active && !flush_req && !stallreq_mem) begin
      if (state_q == IDLE) begin
        mc_done = mc_fire && (len_eff == CNT_W'(1));
      end else begin
        mc_done = cnt_zero;
      end
    end
  end

  assign busy = active && (state_q == MC_RUN);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((ctrl_stall != STALL_NONE) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      stall_cycles_q <= ZERO_WORD;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule
